// File: rtl/ps2_pkg.sv
// Shared PS/2 mouse definitions: init sequencer states, protocol bytes and
// the common WAIT_* state step used by the init controller.
package ps2_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SEND_RST,
        WAIT_ACK1,
        WAIT_BAT,
        WAIT_ID,
        SEND_EN,
        WAIT_ACK2,
        DONE,
        RETRY,
        ERROR
    } ps2_init_state_t;

    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
    localparam logic [7:0] PS2_ACK        = 8'hFA;
    localparam logic [7:0] PS2_BAT_OK     = 8'hAA;
    localparam logic [7:0] PS2_ID_MOUSE   = 8'h00;
    localparam logic [7:0] PS2_RESEND     = 8'hFE;

    // A received byte (matched or not) counts as an event and beats the
    // watchdog on the same cycle; only the expected byte moves forward.
    function automatic ps2_init_state_t wait_step(
        input ps2_init_state_t cur,
        input ps2_init_state_t on_match,
        input logic [7:0]      expect_byte,
        input logic            rx_valid,
        input logic [7:0]      rx_data,
        input logic            tx_err,
        input logic            expired
    );
        ps2_init_state_t nxt;
        nxt = cur;
        if (tx_err)
            nxt = RETRY;
        else if (rx_valid)
            nxt = (rx_data == expect_byte) ? on_match : RETRY;
        else if (expired)
            nxt = RETRY;
        return nxt;
    endfunction

endpackage

// File: rtl/ps2_timeout_timer.sv
// Per-state watchdog: counts enabled cycles since the last clear and flags
// the final cycle of the timeout window.
module ps2_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 40_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    // Saturate at LAST so a held state cannot wrap back into a fresh window.
    always_ff @(posedge clk) begin
        if (rst || clear)
            cnt <= '0;
        else if (enable && cnt != LAST)
            cnt <= cnt + 1'b1;
    end

    assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/ps2_mouse_init_ctl.sv
// PS/2 mouse init sequencer: reset the mouse, check BAT/ID, enable
// streaming, retry on failure and latch an error once retries run out.
module ps2_mouse_init_ctl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 40_000_000,
    parameter int MAX_RETRY      = 3,
    parameter int RETRY_W        = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               reinit,
    output logic               tx_valid,
    output logic [7:0]         tx_data,
    input  logic               tx_ready,
    input  logic               tx_done,
    input  logic               tx_err,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               stream_en,
    output logic               init_done,
    output logic               init_err,
    output logic [RETRY_W-1:0] retry_cnt
);
    ps2_init_state_t state, state_nxt;
    logic            timer_en, timer_clr, expired;
    logic            retry_last;
    logic            unused_tx_done;

    assign unused_tx_done = tx_done;
    assign retry_last     = (retry_cnt == RETRY_W'(MAX_RETRY));

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = SEND_RST;
            SEND_RST: begin
                if (tx_err)        state_nxt = RETRY;
                else if (tx_ready) state_nxt = WAIT_ACK1;
                else if (expired)  state_nxt = RETRY;
            end
            WAIT_ACK1: state_nxt = wait_step(state, WAIT_BAT, PS2_ACK, rx_valid, rx_data, tx_err, expired);
            WAIT_BAT:  state_nxt = wait_step(state, WAIT_ID, PS2_BAT_OK, rx_valid, rx_data, tx_err, expired);
            WAIT_ID:   state_nxt = wait_step(state, SEND_EN, PS2_ID_MOUSE, rx_valid, rx_data, tx_err, expired);
            SEND_EN: begin
                if (tx_err)        state_nxt = RETRY;
                else if (tx_ready) state_nxt = WAIT_ACK2;
                else if (expired)  state_nxt = RETRY;
            end
            WAIT_ACK2: state_nxt = wait_step(state, DONE, PS2_ACK, rx_valid, rx_data, tx_err, expired);
            DONE:      state_nxt = DONE;
            RETRY:     state_nxt = retry_last ? ERROR : SEND_RST;
            ERROR:     state_nxt = ERROR;
            default:   state_nxt = IDLE;
        endcase
        if (reinit)
            state_nxt = SEND_RST;
    end

    always_ff @(posedge clk) begin
        if (rst || reinit)
            retry_cnt <= '0;
        else if (state == RETRY && !retry_last)
            retry_cnt <= retry_cnt + 1'b1;
    end

    // reinit restarts the window even when SEND_RST is re-entered from itself.
    assign timer_en  = (state == SEND_RST) || (state == SEND_EN) || (state == WAIT_ACK1) ||
                       (state == WAIT_BAT) || (state == WAIT_ID) || (state == WAIT_ACK2);
    assign timer_clr = reinit || (state_nxt != state);

    ps2_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clr),
        .enable (timer_en),
        .expired(expired)
    );

    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        stream_en = 1'b0;
        init_done = 1'b0;
        init_err  = 1'b0;
        case (state)
            SEND_RST: begin
                tx_valid = 1'b1;
                tx_data  = PS2_CMD_RESET;
            end
            SEND_EN: begin
                tx_valid = 1'b1;
                tx_data  = PS2_CMD_ENABLE;
            end
            DONE: begin
                stream_en = 1'b1;
                init_done = 1'b1;
            end
            ERROR:   init_err = 1'b1;
            default: ;
        endcase
    end

endmodule
